// File: rtl/idecode_pkg.sv
// ============================================================================
//  idecode_pkg : shared opcodes, format codes, occupancy states and the
//                decoded-payload type for the RV32I/RV64I decode stage
//  Rev 1.0
// ============================================================================
`default_nettype none

package idecode_pkg;

   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      logic [6:0] opcode;
      fmt_e       fmt;
      logic [4:0] rd;
      logic       rd_we;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic       illegal;
   } decode_t;

endpackage

`default_nettype wire

// File: rtl/idecode_if.sv
// ============================================================================
//  idecode_if : fetch-side and execute-side handshake bundle of the decode
//               stage; master = surrounding pipeline, slave = decode stage
//  Rev 1.0
// ============================================================================
`default_nettype none

interface idecode_if
   import idecode_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   fmt_e            out_fmt;
   logic [4:0]      out_rd;
   logic            out_rd_we;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rd,
             out_rd_we, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
             out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rd,
             out_rd_we, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
             out_illegal
   );

endinterface

`default_nettype wire

// File: rtl/idecode_comb.sv
// ============================================================================
//  idecode_comb : combinational instruction word -> decoded payload/immediate
//  Optional macro IDECODE_MULDIV_EN makes the M-extension OP encodings legal.
//  Rev 1.0
// ============================================================================
`default_nettype none

module idecode_comb
   import idecode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output decode_t         o_dec,
   output logic [XLEN-1:0] o_imm
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   fmt_e        w_fmt;
   logic        w_ill;
   logic        w_sh_zero;
   logic        w_sh_sra;
   logic        w_op_ok;
   logic        w_muldiv_ok;
   logic        w_writes;
   logic [4:0]  w_rd;
   logic [63:0] w_imm64;

   assign w_opc = i_instr[6:0];
   assign w_f3  = i_instr[14:12];
   assign w_f7  = i_instr[31:25];

   // RV64 shift amounts are 6 bits wide, so only instr[31:26] qualifies the shift
   assign w_sh_zero = (XLEN == 64) ? (i_instr[31:26] == 6'b000000)
                                   : (w_f7 == 7'b0000000);
   assign w_sh_sra  = (XLEN == 64) ? (i_instr[31:26] == 6'b010000)
                                   : (w_f7 == 7'b0100000);

`ifdef IDECODE_MULDIV_EN
   assign w_muldiv_ok = (w_f7 == 7'b0000001);
`else
   assign w_muldiv_ok = 1'b0;
`endif

   assign w_op_ok = (w_f7 == 7'b0000000)
                  || ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
                  || w_muldiv_ok;

   always_comb begin
      w_fmt = FMT_NONE;
      w_ill = 1'b0;
      case (w_opc)
         LUI, AUIPC:       w_fmt = FMT_U;
         JAL:              w_fmt = FMT_J;
         MISC_MEM, SYSTEM: w_fmt = FMT_I;
         JALR: begin
            w_fmt = FMT_I;
            w_ill = (w_f3 != 3'b000);
         end
         LOAD: begin
            w_fmt = FMT_I;
            w_ill = (w_f3 == 3'b111)
                  || ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
         end
         STORE: begin
            w_fmt = FMT_S;
            w_ill = w_f3[2] || ((XLEN == 32) && (w_f3 == 3'b011));
         end
         BRANCH: begin
            w_fmt = FMT_B;
            w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         OP_IMM: begin
            w_fmt = FMT_I;
            if (w_f3 == 3'b001)
               w_ill = !w_sh_zero;
            else if (w_f3 == 3'b101)
               w_ill = !(w_sh_zero || w_sh_sra);
         end
         OP: begin
            w_fmt = FMT_R;
            w_ill = !w_op_ok;
         end
         default: begin
            w_fmt = FMT_NONE;
            w_ill = 1'b1;
         end
      endcase
      if (i_instr[1:0] != 2'b11)
         w_ill = 1'b1;
   end

   always_comb begin
      w_imm64 = 64'd0;
      case (w_fmt)
         FMT_I: w_imm64 = {{52{i_instr[31]}}, i_instr[31:20]};
         FMT_S: w_imm64 = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B: w_imm64 = {{52{i_instr[31]}}, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
         FMT_U: w_imm64 = {{32{i_instr[31]}}, i_instr[31:12], 12'd0};
         FMT_J: w_imm64 = {{44{i_instr[31]}}, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
         default: w_imm64 = 64'd0;
      endcase
   end

   assign w_rd     = ((w_fmt == FMT_S) || (w_fmt == FMT_B)) ? 5'd0 : i_instr[11:7];
   assign w_writes = (w_fmt == FMT_R) || (w_fmt == FMT_I)
                  || (w_fmt == FMT_U) || (w_fmt == FMT_J);

   assign o_dec.opcode  = w_opc;
   assign o_dec.fmt     = w_fmt;
   assign o_dec.rd      = w_rd;
   assign o_dec.rd_we   = w_writes && (w_rd != 5'd0) && !w_ill;
   assign o_dec.rs1     = i_instr[19:15];
   assign o_dec.rs2     = i_instr[24:20];
   assign o_dec.funct3  = w_f3;
   assign o_dec.funct7  = w_f7;
   assign o_dec.illegal = w_ill;
   assign o_imm         = w_imm64[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/idecode_stage.sv
// ============================================================================
//  idecode_stage : registered decode stage with a two-entry skid buffer
//  Optional macro IDECODE_MULDIV_EN (see idecode_comb).
//  Rev 1.0
// ============================================================================
`default_nettype none

module idecode_stage
   import idecode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   idecode_if.slave bus
);

   occ_e            r_state;
   occ_e            w_next;
   logic            r_in_ready;
   logic            w_out_valid;
   logic            w_accept;
   logic            w_transfer;
   logic            w_load_m;
   logic            w_load_s;
   logic            w_m_from_s;

   decode_t         w_dec;
   logic [XLEN-1:0] w_imm;
   decode_t         r_m_dec;
   logic [XLEN-1:0] r_m_imm;
   logic [XLEN-1:0] r_m_pc;
   decode_t         r_s_dec;
   logic [XLEN-1:0] r_s_imm;
   logic [XLEN-1:0] r_s_pc;

   idecode_comb #(.XLEN(XLEN)) u_comb (
      .i_instr (bus.in_instr),
      .o_dec   (w_dec),
      .o_imm   (w_imm)
   );

   assign w_out_valid = (r_state != OCC_EMPTY);
   assign w_accept    = bus.in_valid && r_in_ready;
   assign w_transfer  = w_out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= OCC_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != OCC_FULL);
      end
   end

   // flush wins over a same-cycle accept, so no load strobe fires under flush
   always_comb begin
      w_next     = r_state;
      w_load_m   = 1'b0;
      w_load_s   = 1'b0;
      w_m_from_s = 1'b0;
      if (flush) begin
         w_next = OCC_EMPTY;
      end else begin
         case (r_state)
            OCC_EMPTY: begin
               if (w_accept) begin
                  w_next   = OCC_ONE;
                  w_load_m = 1'b1;
               end
            end
            OCC_ONE: begin
               if (w_accept && !w_transfer) begin
                  w_next   = OCC_FULL;
                  w_load_s = 1'b1;
               end else if (w_accept) begin
                  w_load_m = 1'b1;
               end else if (w_transfer) begin
                  w_next   = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (w_transfer) begin
                  w_next     = OCC_ONE;
                  w_m_from_s = 1'b1;
               end
            end
            default: w_next = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_m_dec <= '0;
         r_m_imm <= '0;
         r_m_pc  <= '0;
         r_s_dec <= '0;
         r_s_imm <= '0;
         r_s_pc  <= '0;
      end else begin
         if (w_load_m) begin
            r_m_dec <= w_dec;
            r_m_imm <= w_imm;
            r_m_pc  <= bus.in_pc;
         end else if (w_m_from_s) begin
            r_m_dec <= r_s_dec;
            r_m_imm <= r_s_imm;
            r_m_pc  <= r_s_pc;
         end
         if (w_load_s) begin
            r_s_dec <= w_dec;
            r_s_imm <= w_imm;
            r_s_pc  <= bus.in_pc;
         end
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_pc      = r_m_pc;
   assign bus.out_opcode  = r_m_dec.opcode;
   assign bus.out_fmt     = r_m_dec.fmt;
   assign bus.out_rd      = r_m_dec.rd;
   assign bus.out_rd_we   = r_m_dec.rd_we;
   assign bus.out_rs1     = r_m_dec.rs1;
   assign bus.out_rs2     = r_m_dec.rs2;
   assign bus.out_funct3  = r_m_dec.funct3;
   assign bus.out_funct7  = r_m_dec.funct7;
   assign bus.out_imm     = r_m_imm;
   assign bus.out_illegal = r_m_dec.illegal;

endmodule

`default_nettype wire

// File: tb/tb_idecode_stage.sv
// ============================================================================
//  tb_idecode_stage : scoreboard bench for idecode_stage (directed vectors)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_idecode_stage;
   import idecode_pkg::*;

   localparam int XLEN = 32;

`ifdef IDECODE_MULDIV_EN
   localparam logic MUL_ILL = 1'b0;
`else
   localparam logic MUL_ILL = 1'b1;
`endif
   localparam logic LD_ILL = (XLEN == 32);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      fmt;
      logic [4:0]      rd;
      logic            rd_we;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0;
   logic [XLEN-1:0] pc_ctr;
   exp_t exp_q[$];
   exp_t mon_act;
   exp_t mon_exp;

   idecode_if #(.XLEN(XLEN)) bus ();

   idecode_stage #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Raw fields come straight from the instruction word; decoded fields are hand values
   function automatic exp_t mk(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                               input logic [2:0] fmt, input logic [4:0] rd, input logic we,
                               input logic [63:0] imm, input logic ill);
      exp_t e;
      e.pc      = pc;
      e.opcode  = instr[6:0];
      e.fmt     = fmt;
      e.rd      = rd;
      e.rd_we   = we;
      e.rs1     = instr[19:15];
      e.rs2     = instr[24:20];
      e.funct3  = instr[14:12];
      e.funct7  = instr[31:25];
      e.imm     = imm[XLEN-1:0];
      e.illegal = ill;
      return e;
   endfunction

   task automatic send(input logic [31:0] instr, input logic [2:0] fmt, input logic [4:0] rd,
                       input logic we, input logic [63:0] imm, input logic ill);
      int n;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc_ctr;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(mk(instr, pc_ctr, fmt, rd, we, imm, ill));
            break;
         end
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: instr %h not accepted in 50 cycles", instr);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      pc_ctr = pc_ctr + 4;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            mon_act.pc      = bus.out_pc;
            mon_act.opcode  = bus.out_opcode;
            mon_act.fmt     = bus.out_fmt;
            mon_act.rd      = bus.out_rd;
            mon_act.rd_we   = bus.out_rd_we;
            mon_act.rs1     = bus.out_rs1;
            mon_act.rs2     = bus.out_rs2;
            mon_act.funct3  = bus.out_funct3;
            mon_act.funct7  = bus.out_funct7;
            mon_act.imm     = bus.out_imm;
            mon_act.illegal = bus.out_illegal;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got pc=%h with no entry expected", bus.out_pc);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL decode pc=%h: got fmt=%0d rd=%0d we=%b imm=%h ill=%b raw=%h expected fmt=%0d rd=%0d we=%b imm=%h ill=%b raw=%h",
                           mon_exp.pc, mon_act.fmt, mon_act.rd, mon_act.rd_we, mon_act.imm,
                           mon_act.illegal, mon_act, mon_exp.fmt, mon_exp.rd, mon_exp.rd_we,
                           mon_exp.imm, mon_exp.illegal, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'd0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;
      pc_ctr        = 'h100;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_out_pc", 64'(bus.out_pc), 64'd0);
      chk("reset_out_imm", 64'(bus.out_imm), 64'd0);
      chk("reset_out_rd_ill", 64'({bus.out_rd, bus.out_illegal}), 64'd0);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.out_ready = 1'b1;

      // single accept, then a back-to-back stream
      send(32'h123450B7, FMT_U, 5'd1, 1'b1, 64'h0000_0000_1234_5000, 1'b0);
      chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
      t0 = cyc;
      send(32'hFFF1F113, FMT_I,    5'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send(32'hFE000EE3, FMT_B,    5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      send(32'h00512423, FMT_S,    5'd0, 1'b0, 64'd8,                   1'b0);
      send(32'hFFFFF0EF, FMT_J,    5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      send(32'h402081B3, FMT_R,    5'd3, 1'b1, 64'd0,                   1'b0);
      send(32'h402091B3, FMT_R,    5'd3, 1'b0, 64'd0,                   1'b1);
      send(32'h4030D093, FMT_I,    5'd1, 1'b1, 64'h403,                 1'b0);
      send(32'h02000033, FMT_R,    5'd0, 1'b0, 64'd0,                   MUL_ILL);
      send(32'h00003003, FMT_I,    5'd0, 1'b0, 64'd0,                   LD_ILL);
      send(32'h0000007F, FMT_NONE, 5'd0, 1'b0, 64'd0,                   1'b1);
      send(32'h123450B4, FMT_NONE, 5'd1, 1'b0, 64'd0,                   1'b1);
      chk("throughput_cycles", 64'(cyc - t0), 64'd11);
      drain();

      // back-pressure: two held, third waits until the consumer resumes
      bus.out_ready = 1'b0;
      send(32'h00100093, FMT_I, 5'd1, 1'b1, 64'd1, 1'b0);
      send(32'h00200113, FMT_I, 5'd2, 1'b1, 64'd2, 1'b0);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      chk("full_out_valid", 64'(bus.out_valid), 64'd1);
      fork
         send(32'h00300193, FMT_I, 5'd3, 1'b1, 64'd3, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // flush while FULL with an instruction offered in the same cycle
      bus.out_ready = 1'b0;
      send(32'h00400213, FMT_I, 5'd4, 1'b1, 64'd4, 1'b0);
      send(32'h00500293, FMT_I, 5'd5, 1'b1, 64'd5, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00600313;
      bus.in_pc    = pc_ctr;
      flush        = 1'b1;
      @(negedge clk);
      exp_q.delete();
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_full_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // flush in ONE state overrides a same-cycle accept
      bus.out_ready = 1'b0;
      pc_ctr = pc_ctr + 4;
      send(32'h00700393, FMT_I, 5'd7, 1'b1, 64'd7, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00800413;
      bus.in_pc    = pc_ctr;
      flush        = 1'b1;
      @(negedge clk);
      exp_q.delete();
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_one_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      pc_ctr = pc_ctr + 4;
      send(32'h00900493, FMT_I, 5'd9, 1'b1, 64'd9, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
